led_seq_ctrl: RTL

Command-driven sequencer for a single board LED. It owns a shared tick prescaler and a small FSM that runs the LED in one of four modes: off, on, continuous blink, or a counted burst of flashes. Requesters (a debug UART decoder or button logic) issue one command over a valid/ready handshake. The block sits between that control logic and the LED pin, replacing free-running divide-and-toggle blinkers.

---
 rtl/led_seq_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/led_seq_ctrl.sv
// Command-driven LED sequencer: off / on / continuous blink / counted burst,
// timed by a shared tick prescaler that restarts on every accepted command.
module led_seq_ctrl #(
  parameter int TICK_COUNT = 5000000,
  parameter int HALF_W     = 8,
  parameter int REPS_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_mode,
  input  logic [HALF_W-1:0] cmd_half,
  input  logic [REPS_W-1:0] cmd_reps,
  output logic              led,
  output logic              busy,
  output logic              done
);

  localparam int TICK_W = $clog2(TICK_COUNT);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_COUNT - 1);

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_BURST = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_HOLD      = 3'd1,
    S_BLINK     = 3'd2,
    S_BURST_ON  = 3'd3,
    S_BURST_OFF = 3'd4
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [TICK_W-1:0]  tick_cnt_r, tick_cnt_nxt_s;
  logic [HALF_W-1:0]  phase_cnt_r, phase_cnt_nxt_s;
  logic [REPS_W-1:0]  rep_cnt_r, rep_cnt_nxt_s;
  logic [HALF_W-1:0]  half_r, half_nxt_s;
  logic [REPS_W-1:0]  reps_r, reps_nxt_s;
  logic               led_r, led_nxt_s;
  logic               busy_r, busy_nxt_s;
  logic               done_r, done_nxt_s;
  logic               ready_r, ready_nxt_s;

  logic               accept_s;
  logic               tick_s;
  logic               phase_end_s;
  logic [HALF_W-1:0]  half_in_s;
  logic [REPS_W-1:0]  rep_inc_s;

  assign accept_s    = cmd_valid & ready_r;
  assign tick_s      = (tick_cnt_r == TICK_LAST);
  // A phase ends on the tick that completes half ticks since the phase began
  assign phase_end_s = tick_s & (phase_cnt_r == (half_r - HALF_W'(1)));
  assign half_in_s   = (cmd_half == '0) ? HALF_W'(1) : cmd_half;
  assign rep_inc_s   = rep_cnt_r + REPS_W'(1);

  assign cmd_ready = ready_r;
  assign led       = led_r;
  assign busy      = busy_r;
  assign done      = done_r;

  // Next-state, counter and registered-output decode
  always_comb begin
    state_nxt_s     = state_r;
    tick_cnt_nxt_s  = tick_s ? '0 : tick_cnt_r + TICK_W'(1);
    phase_cnt_nxt_s = phase_cnt_r;
    rep_cnt_nxt_s   = rep_cnt_r;
    half_nxt_s      = half_r;
    reps_nxt_s      = reps_r;
    led_nxt_s       = led_r;
    done_nxt_s      = 1'b0;
    if (accept_s) begin
      tick_cnt_nxt_s  = '0;
      phase_cnt_nxt_s = '0;
      rep_cnt_nxt_s   = '0;
      half_nxt_s      = half_in_s;
      reps_nxt_s      = cmd_reps;
      case (cmd_mode)
        MODE_OFF: begin
          state_nxt_s = S_IDLE;
          led_nxt_s   = 1'b0;
        end
        MODE_ON: begin
          state_nxt_s = S_HOLD;
          led_nxt_s   = 1'b1;
        end
        MODE_BLINK: begin
          state_nxt_s = S_BLINK;
          led_nxt_s   = 1'b1;
        end
        MODE_BURST: begin
          if (cmd_reps == '0) begin
            state_nxt_s = S_IDLE;
            led_nxt_s   = 1'b0;
            done_nxt_s  = 1'b1;
          end else begin
            state_nxt_s = S_BURST_ON;
            led_nxt_s   = 1'b1;
          end
        end
        default: begin
          state_nxt_s = S_IDLE;
          led_nxt_s   = 1'b0;
        end
      endcase
    end else begin
      case (state_r)
        S_IDLE: led_nxt_s = 1'b0;
        S_HOLD: led_nxt_s = 1'b1;
        S_BLINK: begin
          if (phase_end_s) begin
            phase_cnt_nxt_s = '0;
            led_nxt_s       = ~led_r;
          end else if (tick_s) begin
            phase_cnt_nxt_s = phase_cnt_r + HALF_W'(1);
          end else begin
            phase_cnt_nxt_s = phase_cnt_r;
          end
        end
        S_BURST_ON: begin
          if (phase_end_s) begin
            phase_cnt_nxt_s = '0;
            state_nxt_s     = S_BURST_OFF;
            led_nxt_s       = 1'b0;
          end else if (tick_s) begin
            phase_cnt_nxt_s = phase_cnt_r + HALF_W'(1);
          end else begin
            phase_cnt_nxt_s = phase_cnt_r;
          end
        end
        S_BURST_OFF: begin
          if (phase_end_s) begin
            phase_cnt_nxt_s = '0;
            rep_cnt_nxt_s   = rep_inc_s;
            if (rep_inc_s == reps_r) begin
              state_nxt_s = S_IDLE;
              led_nxt_s   = 1'b0;
              done_nxt_s  = 1'b1;
            end else begin
              state_nxt_s = S_BURST_ON;
              led_nxt_s   = 1'b1;
            end
          end else if (tick_s) begin
            phase_cnt_nxt_s = phase_cnt_r + HALF_W'(1);
          end else begin
            phase_cnt_nxt_s = phase_cnt_r;
          end
        end
        default: begin
          state_nxt_s = S_IDLE;
          led_nxt_s   = 1'b0;
        end
      endcase
    end
    busy_nxt_s  = (state_nxt_s == S_BURST_ON) || (state_nxt_s == S_BURST_OFF);
    ready_nxt_s = ~busy_nxt_s;
  end

  // State, counters, captured command and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      tick_cnt_r  <= '0;
      phase_cnt_r <= '0;
      rep_cnt_r   <= '0;
      half_r      <= HALF_W'(1);
      reps_r      <= '0;
      led_r       <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      ready_r     <= 1'b1;
    end else begin
      state_r     <= state_nxt_s;
      tick_cnt_r  <= tick_cnt_nxt_s;
      phase_cnt_r <= phase_cnt_nxt_s;
      rep_cnt_r   <= rep_cnt_nxt_s;
      half_r      <= half_nxt_s;
      reps_r      <= reps_nxt_s;
      led_r       <= led_nxt_s;
      busy_r      <= busy_nxt_s;
      done_r      <= done_nxt_s;
      ready_r     <= ready_nxt_s;
    end
  end

endmodule
